// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite compositor and its address helpers.
package sprite_pkg;

   localparam int unsigned MARIO_W  = 26;
   localparam int unsigned MARIO_H  = 32;
   localparam int unsigned TILE     = 32;
   localparam int unsigned GROUND_Y = 416;
   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;

   typedef logic [3:0] pal_code_t;

   localparam pal_code_t PAL_SKY        = 4'd0;
   localparam pal_code_t PAL_BLOCK_BASE = 4'd8;

endpackage

// File: rtl/mario_addr_calc.sv
// Combinational hit test, horizontal mirror and ROM address for a 26x32 sprite.
module mario_addr_calc
   import sprite_pkg::*;
#(
   parameter int unsigned SPR_W = MARIO_W,
   parameter int unsigned SPR_H = MARIO_H
) (
   input  logic [9:0] px,
   input  logic [9:0] py,
   input  logic [9:0] ox,
   input  logic [9:0] oy,
   input  logic       mirror,
   output logic       hit,
   output logic [9:0] addr
);

   logic signed [10:0] dx;
   logic signed [10:0] dy;
   logic [9:0]         col;
   logic [9:0]         row;

   always_comb begin
      // 11-bit signed difference keeps a sprite parked near column 1023 from wrapping onto column 0
      dx   = $signed({1'b0, px}) - $signed({1'b0, ox});
      dy   = $signed({1'b0, py}) - $signed({1'b0, oy});
      hit  = !dx[10] && ($unsigned(dx) < 11'(SPR_W)) &&
             !dy[10] && ($unsigned(dy) < 11'(SPR_H));
      col  = mirror ? (10'(SPR_W - 1) - dx[9:0]) : dx[9:0];
      row  = {5'b0, dy[4:0]};
      addr = '0;
      if (hit) begin
         // row * 26 as shift-add
         addr = (row << 4) + (row << 3) + (row << 1) + col;
      end
   end

endmodule

// File: rtl/sprite_pixel_pipe.sv
// Per-pixel sprite compositor: ROM addressing, ROM latency alignment and Mario/block/sky merge.
module sprite_pixel_pipe #(
   parameter int unsigned MARIO_W  = sprite_pkg::MARIO_W,
   parameter int unsigned MARIO_H  = sprite_pkg::MARIO_H,
   parameter int unsigned TILE     = sprite_pkg::TILE,
   parameter int unsigned GROUND_Y = sprite_pkg::GROUND_Y
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       pix_valid,
   input  logic [9:0] draw_x,
   input  logic [9:0] draw_y,
   input  logic [9:0] mario_x_in,
   input  logic [9:0] mario_y_in,
   input  logic       mario_left_in,
   output logic [9:0] mario_addr,
   input  logic [2:0] mario_q,
   output logic [9:0] block_addr,
   input  logic [1:0] block_q,
   output logic [3:0] pix_color,
   output logic       pix_out_valid
);

   import sprite_pkg::*;

   localparam int unsigned TB = $clog2(TILE);
   localparam logic [9:0]  GY = 10'(GROUND_Y);

   logic [9:0]    act_x;
   logic [9:0]    act_y;
   logic          act_left;

   logic          m_hit_c;
   logic [9:0]    m_addr_c;
   logic          b_hit_c;
   logic [9:0]    b_addr_c;
   logic [TB-1:0] tile_row;

   logic [1:0]    m_hit_sr;
   logic [1:0]    b_hit_sr;
   logic [1:0]    vld_sr;
   pal_code_t     color_c;

   mario_addr_calc #(
      .SPR_W (MARIO_W),
      .SPR_H (MARIO_H)
   ) u_mario_addr (
      .px     (draw_x),
      .py     (draw_y),
      .ox     (act_x),
      .oy     (act_y),
      .mirror (act_left),
      .hit    (m_hit_c),
      .addr   (m_addr_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_x    <= '0;
         act_y    <= '0;
         act_left <= 1'b0;
      end else if (frame_start) begin
         act_x    <= mario_x_in;
         act_y    <= mario_y_in;
         act_left <= mario_left_in;
      end
   end

   always_comb begin
      b_hit_c  = pix_valid && (draw_y >= GY);
      tile_row = draw_y[TB-1:0] - GY[TB-1:0];
      b_addr_c = '0;
      if (b_hit_c) begin
         b_addr_c = 10'({tile_row, draw_x[TB-1:0]});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mario_addr <= '0;
         block_addr <= '0;
         m_hit_sr   <= '0;
         b_hit_sr   <= '0;
         vld_sr     <= '0;
      end else begin
         mario_addr <= (pix_valid && m_hit_c) ? m_addr_c : '0;
         block_addr <= b_addr_c;
         m_hit_sr   <= {m_hit_sr[0], pix_valid && m_hit_c};
         b_hit_sr   <= {b_hit_sr[0], b_hit_c};
         vld_sr     <= {vld_sr[0], pix_valid};
      end
   end

   // flags in stage [1] line up with ROM data registered one cycle after the address
   always_comb begin
      color_c = PAL_SKY;
      if (vld_sr[1]) begin
         if (m_hit_sr[1] && (mario_q != 3'd0)) begin
            color_c = {1'b0, mario_q};
         end else if (b_hit_sr[1]) begin
            color_c = PAL_BLOCK_BASE | {2'b00, block_q};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_color     <= '0;
         pix_out_valid <= 1'b0;
      end else begin
         pix_color     <= color_c;
         pix_out_valid <= vld_sr[1];
      end
   end

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Bench for sprite_pixel_pipe: ROM models, arithmetic reference model, directed and random pixels.
module tb_sprite_pixel_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       frame_start = 1'b0;
   logic       pix_valid = 1'b0;
   logic [9:0] draw_x = '0;
   logic [9:0] draw_y = '0;
   logic [9:0] mario_x_in = '0;
   logic [9:0] mario_y_in = '0;
   logic       mario_left_in = 1'b0;
   logic [9:0] mario_addr;
   logic [2:0] mario_q;
   logic [9:0] block_addr;
   logic [1:0] block_q;
   logic [3:0] pix_color;
   logic       pix_out_valid;

   logic [2:0] mrom [0:1023];
   logic [1:0] brom [0:1023];

   int         exp_ma  [0:8191];
   int         exp_ba  [0:8191];
   int         exp_col [0:8191];
   logic       exp_v   [0:8191];
   int         cyc = 0;
   int         m_ax = 0;
   int         m_ay = 0;
   logic       m_al = 1'b0;

   int         n_checks = 0;
   int         n_fail = 0;

   sprite_pixel_pipe #(
      .MARIO_W  (26),
      .MARIO_H  (32),
      .TILE     (32),
      .GROUND_Y (416)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_start   (frame_start),
      .pix_valid     (pix_valid),
      .draw_x        (draw_x),
      .draw_y        (draw_y),
      .mario_x_in    (mario_x_in),
      .mario_y_in    (mario_y_in),
      .mario_left_in (mario_left_in),
      .mario_addr    (mario_addr),
      .mario_q       (mario_q),
      .block_addr    (block_addr),
      .block_q       (block_q),
      .pix_color     (pix_color),
      .pix_out_valid (pix_out_valid)
   );

   always #5 clk = ~clk;

   // Synchronous-read ROMs, one cycle of latency
   always @(posedge clk) begin
      mario_q <= mrom[mario_addr];
      block_q <= brom[block_addr];
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Present one pixel, predict its addresses and colour, then check this cycle's addresses
   // and the colour of the pixel presented two calls earlier.
   task automatic drive(input logic fs, input logic pv, input int x, input int y);
      int dx, dy, ma, ba;
      logic mh, bh;
      frame_start = fs;
      pix_valid   = pv;
      draw_x      = 10'(x);
      draw_y      = 10'(y);
      dx = x - m_ax;
      dy = y - m_ay;
      mh = pv && (dx >= 0) && (dx < 26) && (dy >= 0) && (dy < 32);
      bh = pv && (y >= 416);
      ma = mh ? (dy * 26 + (m_al ? (25 - dx) : dx)) : 0;
      ba = bh ? (((y - 416) % 32) * 32 + (x % 32)) : 0;
      exp_ma[cyc] = ma;
      exp_ba[cyc] = ba;
      exp_v[cyc]  = pv;
      if (!pv)                         exp_col[cyc] = 0;
      else if (mh && mrom[ma] != 3'd0) exp_col[cyc] = int'(mrom[ma]);
      else if (bh)                     exp_col[cyc] = 8 + int'(brom[ba]);
      else                             exp_col[cyc] = 0;
      if (fs) begin
         m_ax = int'(mario_x_in);
         m_ay = int'(mario_y_in);
         m_al = mario_left_in;
      end
      @(posedge clk);
      #1;
      check_eq("mario_addr", 16'(mario_addr), 16'(exp_ma[cyc]));
      check_eq("block_addr", 16'(block_addr), 16'(exp_ba[cyc]));
      if (cyc >= 2) begin
         check_eq("pix_out_valid", 16'(pix_out_valid), 16'(exp_v[cyc-2]));
         check_eq("pix_color", 16'(pix_color), 16'(exp_col[cyc-2]));
      end
      cyc++;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 0, 0);
   endtask

   task automatic do_reset();
      frame_start = 1'b0;
      pix_valid   = 1'b0;
      rst_n       = 1'b0;
      #1;
      check_eq("rst_mario_addr", 16'(mario_addr), 16'd0);
      check_eq("rst_block_addr", 16'(block_addr), 16'd0);
      check_eq("rst_pix_color", 16'(pix_color), 16'd0);
      check_eq("rst_pix_valid", 16'(pix_out_valid), 16'd0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_hold_valid", 16'(pix_out_valid), 16'd0);
      rst_n = 1'b1;
      m_ax = 0;
      m_ay = 0;
      m_al = 1'b0;
      // pixels still in flight at reset are discarded
      if (cyc >= 1) begin exp_v[cyc-1] = 1'b0; exp_col[cyc-1] = 0; end
      if (cyc >= 2) begin exp_v[cyc-2] = 1'b0; exp_col[cyc-2] = 0; end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mrom[i] = 3'($urandom);
         brom[i] = 2'($urandom);
      end
      mrom[0]   = 3'd3;
      brom[133] = 2'd2;
      mrom[530] = 3'd0;
      mrom[531] = 3'd5;
      brom[150] = 2'd1;

      #2;
      do_reset();

      // default active position (0,0), right-facing
      drive(1'b0, 1'b1, 0, 0);
      check_eq("p00_addr", 16'(mario_addr), 16'd0);
      idle();
      idle();
      check_eq("p00_valid", 16'(pix_out_valid), 16'd1);
      check_eq("p00_color", 16'(pix_color), 16'd3);

      // latch (100,200) right then left
      mario_x_in = 10'd100; mario_y_in = 10'd200; mario_left_in = 1'b0;
      drive(1'b1, 1'b0, 0, 0);
      drive(1'b0, 1'b1, 101, 201);
      check_eq("addr_right", 16'(mario_addr), 16'd27);
      mario_left_in = 1'b1;
      drive(1'b1, 1'b0, 0, 0);
      drive(1'b0, 1'b1, 101, 201);
      check_eq("addr_left", 16'(mario_addr), 16'd50);

      // ground block only
      drive(1'b0, 1'b1, 5, 420);
      check_eq("blk_addr", 16'(block_addr), 16'd133);
      idle();
      idle();
      check_eq("blk_color", 16'(pix_color), 16'd10);

      // Mario over ground: transparent texel then opaque texel
      mario_x_in = 10'd300; mario_y_in = 10'd400; mario_left_in = 1'b0;
      drive(1'b1, 1'b0, 0, 0);
      drive(1'b0, 1'b1, 310, 420);
      check_eq("ovl_addr0", 16'(mario_addr), 16'd530);
      drive(1'b0, 1'b1, 311, 420);
      check_eq("ovl_addr1", 16'(mario_addr), 16'd531);
      idle();
      check_eq("ovl_transparent", 16'(pix_color), 16'd9);
      idle();
      check_eq("ovl_opaque", 16'(pix_color), 16'd5);

      // position change without frame_start, then with a simultaneous pixel
      mario_x_in = 10'd50;
      drive(1'b0, 1'b1, 310, 420);
      check_eq("nolatch_addr", 16'(mario_addr), 16'd530);
      mario_x_in = 10'd305;
      drive(1'b1, 1'b1, 310, 420);
      check_eq("same_cycle_addr", 16'(mario_addr), 16'd530);
      drive(1'b0, 1'b1, 310, 420);
      check_eq("new_pos_addr", 16'(mario_addr), 16'd525);

      // right screen edge
      mario_x_in = 10'd630; mario_y_in = 10'd100; mario_left_in = 1'b0;
      drive(1'b1, 1'b0, 0, 0);
      for (int x = 620; x < 640; x++) begin
         drive(1'b0, 1'b1, x, 110);
         if (x == 629) check_eq("edge_miss", 16'(mario_addr), 16'd0);
         if (x == 630) check_eq("edge_hit", 16'(mario_addr), 16'd260);
         if (x == 639) check_eq("edge_last", 16'(mario_addr), 16'd269);
      end

      // sprite beyond the visible area must not wrap to low columns
      mario_x_in = 10'd1020;
      drive(1'b1, 1'b0, 0, 0);
      for (int x = 0; x < 6; x++) begin
         drive(1'b0, 1'b1, x, 110);
      end
      check_eq("nowrap_addr", 16'(mario_addr), 16'd0);

      // reset in the middle of a line
      drive(1'b0, 1'b1, 200, 420);
      drive(1'b0, 1'b1, 201, 420);
      do_reset();
      idle();
      drive(1'b0, 1'b1, 7, 430);
      check_eq("post_rst_v1", 16'(pix_out_valid), 16'd0);
      idle();
      check_eq("post_rst_v2", 16'(pix_out_valid), 16'd0);
      idle();
      check_eq("post_rst_v3", 16'(pix_out_valid), 16'd1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic fs;
         logic pv;
         int   x;
         int   y;
         fs = ($urandom_range(0, 49) == 0);
         if (fs) begin
            mario_x_in    = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(600, 1023))
                                                        : 10'($urandom_range(0, 639));
            mario_y_in    = 10'($urandom_range(0, 479));
            mario_left_in = 1'($urandom);
         end else if ($urandom_range(0, 19) == 0) begin
            mario_x_in = 10'($urandom_range(0, 1023));
            mario_y_in = 10'($urandom_range(0, 479));
         end
         pv = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 1) == 1) begin
            x = m_ax + int'($urandom_range(0, 35)) - 4;
            y = m_ay + int'($urandom_range(0, 40)) - 4;
         end else begin
            x = int'($urandom_range(0, 639));
            y = int'($urandom_range(380, 479));
         end
         if (x < 0) x = 0;
         if (x > 639) x = 639;
         if (y < 0) y = 0;
         if (y > 479) y = 479;
         drive(fs, pv, x, y);
      end
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
